relobi_tmr_rr_arb: RTL
======================

// Module: relobi_tmr_rr_arb
// PURPOSE
//  Round-robin arbiter sharing one OBI manager port between NumSbrPorts requesters (A-channel req/gnt).
//  Drives the select of the per-manager-port mux in the reliable xbar.
//  Arbitration state is triplicated and majority-voted every cycle; single-copy upsets are corrected and flagged.
//  Holds its decision stable while a request waits for gnt, as OBI requires.
// PARAMETERS
//  NumSbrPorts  4                      number of requesters, >=2
//  IdxWidth     $clog2(NumSbrPorts)    width of a requester index (localparam, not overridable)
// PORTS
//  clk_i       in   1                           clock
//  rst_ni      in   1                           asynchronous reset, active low
//  req_i       in   NumSbrPorts                 per-requester OBI req
//  gnt_o       out  NumSbrPorts                 per-requester OBI gnt
//  req_o       out  1                           req towards manager port
//  gnt_i       in   1                           gnt from manager port
//  idx_o       out  [3][IdxWidth]               three identical copies of the winner index, one per mux replica
//  fault_o     out  1                           registered: a state copy disagreed with the vote last cycle
// BEHAVIOUR
//  State per copy c in 0..2: ptr[c] (IdxWidth), lock[c] (1), lidx[c] (IdxWidth).
//  Voting and fault detection
//   - Every cycle, vptr/vlock/vlidx = bitwise 2-of-3 majority over the three copies.
//   - All logic uses only voted values; every copy is written from the same voted next-state.
//   - A flipped copy is therefore rewritten on the next clock edge.
//  Winner selection
//   - vlock=1: winner = vlidx.
//   - vlock=0: winner = first k with req_i[k]=1, scanning vptr, vptr+1, ... with wrap at NumSbrPorts-1 -> 0.
//   - No request and vlock=0: winner = vptr.
//  Outputs, all combinational, zero latency
//   - req_o = vlock ? req_i[vlidx] : |req_i.
//   - gnt_o[winner] = req_o & gnt_i; all other gnt_o bits are 0.
//   - idx_o[0..2] = winner, computed as three separate logic copies (not shared).
//  Next state
//   - Handshake (req_o & gnt_i): ptr <= winner+1 (winner == NumSbrPorts-1 -> 0); lock <= 0.
//   - req_o & !gnt_i: lock <= 1; lidx <= winner; ptr unchanged.
//   - vlock=1 and req_i[vlidx]=0 (requester withdrew; protocol violation): lock <= 0; ptr unchanged; no fault flagged.
//   - Otherwise state holds.
//  Boundary cases
//   - Single requester: granted back-to-back every cycle gnt_i=1.
//   - All requesting: strict rotation, one handshake each, starting at vptr.
//   - A new request arriving while locked does not change winner.
//  Fault flag
//   - fault_o <= |(copy != voted) over all fields, registered one cycle.
//  Reset (asynchronous, mid-operation included)
//   - All copies: ptr=0, lock=0, lidx=0; fault_o=0.
//   - Combinational outputs then follow the rules above with ptr=0.
// CONFIGURATION
//  RELOBI_TMR_ARB_FAULT_CNT_EN defined:
//   - Adds port fault_cnt_o (out, 8): saturating count of cycles with fault_o=1.
//   - Reset value 0; holds at 255.
//  Not defined: port and counter are absent; fault_o is unchanged.
// STRUCTURE
//  Package relobi_tmr_pkg:
//   - function maj3 (bitwise 2-of-3 vote, parameterized width via let/macro-free automatic function on logic vectors)
//   - typedef rr_arb_state_t {ptr, lock, lidx} sized by the instantiating module.
//  Sub-module relobi_rr_pick: combinational rotate-priority finder (req, start ptr -> idx, valid).
//   - Instantiated three times, once per idx_o copy.
// TESTING
//  1. Reset, req_i=4'b1111, gnt_i=1 for 8 cycles -> winners 0,1,2,3,0,1,2,3; exactly one gnt_o bit high per cycle.
//  2. req_i=4'b0100, gnt_i=0 for 3 cycles, then raise req_i[0]:
//     -> idx_o stays 2 and req_o=1 until gnt_i=1; then ptr=3 and next winner is 0.
//  3. Force ptr copy 1 to 2 while copies 0,2 hold 0:
//     -> winner uses ptr 0; fault_o=1 next cycle; copy 1 back to 0 after one edge; fault_o=0 one cycle later.
//  4. Lock on idx 1 (gnt_i=0), then drop req_i[1]:
//     -> req_o=0 that cycle; lock cleared next cycle; ptr unchanged; fault_o stays 0.
//  5. rst_ni low mid-lock with req_i=4'b1000:
//     -> immediately ptr=0, lock=0, idx_o=3, req_o=1, fault_o=0.
//  6. With RELOBI_TMR_ARB_FAULT_CNT_EN, inject 300 single-copy faults -> fault_cnt_o saturates at 255.

Source files
------------

// File: rtl/relobi_tmr_pkg.sv
// Shared helpers for the triplicated relobi round-robin arbiter.
// The majority vote is applied to zero-extended fields and cast back by the caller.
package relobi_tmr_pkg;

    localparam int unsigned NumCopies = 3;
    localparam int unsigned VoteWidth = 32;

    function automatic logic [VoteWidth-1:0] maj3(
        input logic [VoteWidth-1:0] a,
        input logic [VoteWidth-1:0] b,
        input logic [VoteWidth-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/relobi_rr_pick.sv
// Rotate-priority finder: first requester at or after start_i, wrapping around.
// With no request pending, idx_o falls back to start_i and valid_o stays low.
module relobi_rr_pick #(
    parameter int unsigned NumSbrPorts = 4,
    localparam int unsigned IdxWidth = $clog2(NumSbrPorts)
) (
    input  logic [NumSbrPorts-1:0] req_i,
    input  logic [IdxWidth-1:0]    start_i,
    output logic [IdxWidth-1:0]    idx_o,
    output logic                   valid_o
);

    int unsigned pos;

    // Scan from the farthest position back towards start_i so the nearest requester is written last.
    always_comb begin
        idx_o   = start_i;
        valid_o = 1'b0;
        pos     = 0;
        for (int i = NumSbrPorts - 1; i >= 0; i--) begin
            pos = (int'(start_i) + i) % NumSbrPorts;
            if (req_i[pos]) begin
                idx_o   = IdxWidth'(pos);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/relobi_tmr_rr_arb.sv
// Round-robin OBI arbiter with triplicated, majority-voted arbitration state.
// Optional macro RELOBI_TMR_ARB_FAULT_CNT_EN adds a saturating fault counter port fault_cnt_o.
module relobi_tmr_rr_arb
    import relobi_tmr_pkg::*;
#(
    parameter int unsigned NumSbrPorts = 4,
    localparam int unsigned IdxWidth = $clog2(NumSbrPorts)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumSbrPorts-1:0]            req_i,
    output logic [NumSbrPorts-1:0]            gnt_o,
    output logic                              req_o,
    input  logic                              gnt_i,
    output logic [NumCopies-1:0][IdxWidth-1:0] idx_o,
    output logic                              fault_o
`ifdef RELOBI_TMR_ARB_FAULT_CNT_EN
    ,
    output logic [7:0]                        fault_cnt_o
`endif
);

    typedef struct packed {
        logic [IdxWidth-1:0] ptr;
        logic                lock;
        logic [IdxWidth-1:0] lidx;
    } rr_arb_state_t;

    rr_arb_state_t        state_cp [NumCopies];
    rr_arb_state_t        voted;
    rr_arb_state_t        next_state;
    logic [IdxWidth-1:0]  pick_idx [NumCopies];
    logic [IdxWidth-1:0]  win      [NumCopies];
    logic [NumCopies-1:0] pick_valid;
    logic                 handshake;
    logic                 mismatch;
    logic                 fault_q;

    // Each copy owns its registers and its own picker so a single upset cannot corrupt all idx_o replicas.
    for (genvar c = 0; c < NumCopies; c++) begin : g_copy
        logic [IdxWidth-1:0] ptr_q;
        logic                lock_q;
        logic [IdxWidth-1:0] lidx_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ptr_q  <= '0;
                lock_q <= 1'b0;
                lidx_q <= '0;
            end else begin
                ptr_q  <= next_state.ptr;
                lock_q <= next_state.lock;
                lidx_q <= next_state.lidx;
            end
        end

        assign state_cp[c] = {ptr_q, lock_q, lidx_q};

        relobi_rr_pick #(
            .NumSbrPorts(NumSbrPorts)
        ) i_pick (
            .req_i  (req_i),
            .start_i(voted.ptr),
            .idx_o  (pick_idx[c]),
            .valid_o(pick_valid[c])
        );

        assign win[c]   = voted.lock ? voted.lidx : pick_idx[c];
        assign idx_o[c] = win[c];
    end

    always_comb begin
        voted.ptr  = IdxWidth'(maj3(VoteWidth'(state_cp[0].ptr), VoteWidth'(state_cp[1].ptr),
                                    VoteWidth'(state_cp[2].ptr)));
        voted.lock = 1'(maj3(VoteWidth'(state_cp[0].lock), VoteWidth'(state_cp[1].lock),
                             VoteWidth'(state_cp[2].lock)));
        voted.lidx = IdxWidth'(maj3(VoteWidth'(state_cp[0].lidx), VoteWidth'(state_cp[1].lidx),
                                    VoteWidth'(state_cp[2].lidx)));
        mismatch = 1'b0;
        for (int c = 0; c < NumCopies; c++) begin
            mismatch = mismatch | (state_cp[c] != voted);
        end
    end

    assign req_o = voted.lock ? req_i[voted.lidx]
                              : 1'(maj3(VoteWidth'(pick_valid[0]), VoteWidth'(pick_valid[1]),
                                        VoteWidth'(pick_valid[2])));
    assign handshake = req_o & gnt_i;

    always_comb begin
        gnt_o         = '0;
        gnt_o[win[0]] = handshake;
    end

    // A locked requester that drops req is treated as a withdrawal: unlock without moving the pointer.
    always_comb begin
        next_state = voted;
        if (handshake) begin
            next_state.ptr  = (win[0] == IdxWidth'(NumSbrPorts - 1)) ? '0 : win[0] + IdxWidth'(1);
            next_state.lock = 1'b0;
        end else if (req_o) begin
            next_state.lock = 1'b1;
            next_state.lidx = win[0];
        end else if (voted.lock) begin
            next_state.lock = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= mismatch;
        end
    end

    assign fault_o = fault_q;

`ifdef RELOBI_TMR_ARB_FAULT_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_cnt_o <= 8'd0;
        end else if (fault_q && (fault_cnt_o != 8'hFF)) begin
            fault_cnt_o <= fault_cnt_o + 8'd1;
        end
    end
`endif

endmodule
